// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver: FSM state encoding,
// parity-mode constants and a 2-of-3 vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_EVEN = 1;
    localparam int UART_PARITY_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-word FIFO with a registered head word. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic          rd_en,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, wptr_n, rptr_n, count_n;
    logic [WIDTH-1:0] head_n;
    logic             wr_ok, rd_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign rd_ok = rd_en && !empty;
    // A full FIFO still accepts a word when the head is popped in the same cycle.
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        wptr_n  = wptr + (AW+1)'(wr_ok);
        rptr_n  = rptr + (AW+1)'(rd_ok);
        count_n = wptr_n - rptr_n;
        head_n  = '0;
        if (count_n != '0) begin
            // Bypass when the word being written lands in the next head slot.
            if (wr_ok && (rptr_n[AW-1:0] == wptr[AW-1:0]))
                head_n = wr_data;
            else
                head_n = mem[rptr_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            head <= '0;
        end else begin
            wptr <= wptr_n;
            rptr <= rptr_n;
            head <= head_n;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver feeding a small word FIFO.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit instead of one sample.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_baud_tick,
    input  logic                          rx_in,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = OVERSAMPLE / 2;

    logic sync1, sync2, rxs;
    logic bit_val;

    uart_rx_state_t       state, state_n;
    logic [CW-1:0]        tcnt, tcnt_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n, ferr, ferr_n, ferr_new, par_x;
    logic                 samp, push;
    logic [DATA_BITS+1:0] push_word, head;
    logic                 fifo_full, fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end
    assign rxs = sync2;

    // Every bit decision lands one tick after the nominal mid sample, so the
    // frame timing does not depend on which sampling scheme is built.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            hist <= 2'b11;
        else if (rx_baud_tick) hist <= {hist[0], rxs};
    end
    assign bit_val = maj3(hist[1], hist[0], rxs);
`else
    logic hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            hist <= 1'b1;
        else if (rx_baud_tick) hist <= rxs;
    end
    assign bit_val = hist;
`endif

    assign samp  = rx_baud_tick &&
                   (tcnt == ((state == START) ? CW'(MID) : CW'(OVERSAMPLE - 1)));
    assign par_x = (^shreg) ^ bit_val;

    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        bcnt_n    = bcnt;
        shreg_n   = shreg;
        perr_n    = perr;
        ferr_n    = ferr;
        ferr_new  = ferr | ~bit_val;
        push      = 1'b0;
        push_word = {perr, ferr_new, shreg};

        if (rx_baud_tick && (state inside {START, DATA, PARITY, STOP}))
            tcnt_n = samp ? '0 : tcnt + 1'b1;

        case (state)
            IDLE: begin
                tcnt_n = '0;
                bcnt_n = '0;
                perr_n = 1'b0;
                ferr_n = 1'b0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (samp) state_n = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (samp) begin
                    shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
                    if (bcnt == BW'(DATA_BITS - 1)) begin
                        bcnt_n  = '0;
                        state_n = (PARITY_MODE != UART_PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (samp) begin
                    perr_n  = (PARITY_MODE == UART_PARITY_ODD) ? ~par_x : par_x;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (samp) begin
                    ferr_n = ferr_new;
                    if (bcnt == BW'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        bcnt_n  = '0;
                        state_n = ferr_new ? WAIT_IDLE : IDLE;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
            perr  <= perr_n;
            ferr  <= ferr_n;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (rd_en),
        .head    (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Overrun set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_overrun <= 1'b0;
        else if (push && fifo_full && !(rd_en && !fifo_empty))
            rx_overrun <= 1'b1;
        else if (ovr_clr)
            rx_overrun <= 1'b0;
    end

    assign rx_valid      = !fifo_empty;
    assign rx_data       = head[DATA_BITS-1:0];
    assign rx_frame_err  = head[DATA_BITS];
    assign rx_parity_err = head[DATA_BITS+1];

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, oversampling UART receiver: the next-generation replacement for the fixed 8N1 receiver. Consumes the oversampled `rx_baud_tick` from `baud_rate_generator`, supports configurable data width, parity and stop bits, and buffers received words with per-word error flags in a small FIFO with a read handshake. It sits between the pad-side `rx_in` line and the consumer logic.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `OVERSAMPLE`, 16: `rx_baud_tick` pulses per bit period; even, ≥ 8.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_baud_tick`  in  1  one-cycle pulse, `OVERSAMPLE` per bit.
- `rx_in`  in  1  serial line, idle high, asynchronous to `clk`.
- `rd_en`  in  1  pop head word; ignored when `rx_valid` = 0.
- `ovr_clr`  in  1  clears sticky `rx_overrun`.
- `rx_data`  out  DATA_BITS  head-of-FIFO data.
- `rx_valid`  out  1  FIFO not empty.
- `rx_frame_err`  out  1  head word stop-bit error.
- `rx_parity_err`  out  1  head word parity error; always 0 when `PARITY_MODE` = 0.
- `rx_overrun`  out  1  sticky: a word was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Reset values: all outputs 0. The synchroniser flops and the sampled-line register reset to 1, and the FSM resets to IDLE.
- `rx_in` passes through a 2-FF synchroniser. All FSM decisions use the synchronised value `rxs`.
- The FSM has states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- The tick counter counts only on `rx_baud_tick`.
- IDLE:
  - Enter START on `rxs` = 0.
  - Clear the tick counter and the bit counter.
- START:
  - At tick `OVERSAMPLE/2 - 1`, sample the line.
  - If the sample is 1, treat it as a false start and return to IDLE.
  - Otherwise restart the counter and go to DATA.
- DATA:
  - Sample every `OVERSAMPLE` ticks.
  - Shift the sample into a `DATA_BITS` register, LSB first.
  - After `DATA_BITS` samples, go to PARITY if `PARITY_MODE` ≠ 0, else go to STOP.
- PARITY:
  - Take one sample.
  - Error if the XOR of the data bits and the sample is 1 (even mode) or 0 (odd mode).
- STOP:
  - Take `STOP_BITS` samples. Any 0 sample sets the frame error.
  - After the last stop sample, write {parity_err, frame_err, data} to the FIFO.
  - Then go to IDLE if there was no frame error, else go to WAIT_IDLE.
- WAIT_IDLE: return to IDLE only once `rxs` = 1. This prevents a break or glitch from retriggering.
- FIFO behaviour:
  - Push and pop in the same cycle: both occur and `fifo_count` is unchanged.
  - Push while full and no pop: the word is dropped, `rx_overrun` is set, and FIFO contents are unchanged.
  - Push while full with a simultaneous pop: accepted, no overrun.
  - `rd_en` while empty: no effect, no pointer movement.
  - Pointers wrap modulo `FIFO_DEPTH`, with one extra bit for full/empty.
- `rx_overrun` clears on `ovr_clr`. If a set condition and `ovr_clr` occur in the same cycle, set wins.
- `rst_n` asserted mid-frame: immediate return to IDLE, FIFO emptied, partial word discarded.

## Timing
- Line to FSM: 2 `clk` cycles of synchroniser latency.
- FIFO write: on the `clk` edge after the cycle carrying the final stop-sample tick.
- `rx_valid`, `rx_data` and the error flags are registered FIFO head outputs, valid the cycle after the write.
- Pop: `rd_en` sampled high at edge N; the next head (or `rx_valid` = 0) is visible after edge N.
- A new start bit is accepted from the first IDLE cycle following the stop sample. Back-to-back frames are supported.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: each bit value is the 2-of-3 majority of samples at mid-bit ticks (mid-1, mid, mid+1). This applies to the START check, data, parity and stop samples.
  - Undefined: a single sample at the mid tick.
- Frame timing is identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum `uart_rx_state_t`;
  - the parity-mode constants `UART_PARITY_NONE`, `UART_PARITY_EVEN`, `UART_PARITY_ODD`.
- Sub-module `uart_rx_fifo`:
  - synchronous FIFO, width `DATA_BITS+2`, depth `FIFO_DEPTH`;
  - registered head output, with count, full and empty.

## Test plan
Each scenario uses a 50 MHz clock, 115200 baud and 16× ticks from `baud_rate_generator`.
- 8N1: send 0xA5 then 0x3C back-to-back, no `rd_en` → `fifo_count` = 2; pop twice gives 0xA5 then 0x3C, both error flags 0.
- `DATA_BITS`=7, even parity: send 0x55 with correct parity → `rx_parity_err` = 0; resend with parity bit inverted → 0x55 with `rx_parity_err` = 1.
- Stop bit held 0 on 0xB4 → word 0xB4 with `rx_frame_err` = 1. The FSM stays in WAIT_IDLE until the line goes high, then 0x12 is received cleanly.
- `FIFO_DEPTH`=4: send 5 words without reading → `rx_overrun` = 1, `fifo_count` = 4, and the first 4 words are read intact. A pulse on `ovr_clr` → `rx_overrun` = 0.
- Glitch: a 3-tick low pulse on `rx_in` → no word written, FSM returns to IDLE. With `UART_RX_MAJORITY_EN`, a 1-tick inverted glitch at mid-bit of 0xA5 → 0xA5 still received.
- Assert `rst_n` mid-frame after 4 data bits → all outputs 0 and FIFO empty. The next full frame 0x5A is received correctly.
